// File: rtl/dispatch_queue_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_queue_pkg
//   Shared definitions for the decode -> reservation-station dispatch queue:
//   default depth, pointer/count typedefs and the ID_RS_PACKET carried from
//   decode to the reservation station.
//   No ports (package).
// -----------------------------------------------------------------------------
package dispatch_queue_pkg;

    localparam int DQ_DEPTH = 8;
    localparam int DQ_PTR_W = $clog2(DQ_DEPTH);
    localparam int DQ_CNT_W = $clog2(DQ_DEPTH + 1);

    typedef logic [DQ_PTR_W-1:0] DQ_PTR;
    typedef logic [DQ_CNT_W-1:0] DQ_CNT;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MULT   = 3'd1,
        FU_LOAD   = 3'd2,
        FU_STORE  = 3'd3,
        FU_BRANCH = 3'd4
    } FU_TYPE;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        FU_TYPE      fu_type;
        logic [4:0]  dest_reg_idx;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic        valid;
    } ID_RS_PACKET;

    localparam int ID_RS_PKT_W = $bits(ID_RS_PACKET);

endpackage

// File: rtl/dispatch_queue.sv
// -----------------------------------------------------------------------------
// dispatch_queue
//   In-order FIFO between decode and the reservation station. Decode keeps
//   issuing while the RS has no free entry; the oldest packet is presented
//   to the RS with a valid/ready handshake. A squash empties the queue.
//
//   Optional feature: define DQ_BYPASS_EN to pass a packet straight from
//   decode to the RS when the queue is empty and the RS is ready (zero-cycle
//   latency, nothing written). Undefined by default.
//
// Ports
//   clock      in   system clock, posedge
//   reset      in   synchronous active-high reset
//   squash     in   flush all entries (mispredict recovery)
//   id_valid   in   decode presents a packet
//   id_packet  in   packet from decode (ID_RS_PACKET, packed)
//   id_ready   out  queue can accept a packet (= !full)
//   rs_ready   in   RS can allocate the head packet
//   dq_valid   out  head packet valid
//   dq_packet  out  head packet ('0 when nothing to present)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  current occupancy
// -----------------------------------------------------------------------------
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash,
    input  logic                   id_valid,
    input  logic [ID_RS_PKT_W-1:0] id_packet,
    output logic                   id_ready,
    input  logic                   rs_ready,
    output logic                   dq_valid,
    output logic [ID_RS_PKT_W-1:0] dq_packet,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ID_RS_PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   enq, deq, bypass;

    // Status, handshake and head read are all derived from registered state
    // (plus the bypass path when enabled).
    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        id_ready = !full;
        count    = count_q;

`ifdef DQ_BYPASS_EN
        bypass = empty && id_valid && rs_ready && !squash;
`else
        bypass = 1'b0;
`endif

        dq_valid  = !empty || bypass;
        dq_packet = '0;
        if (!empty) begin
            dq_packet = mem_q[head_q];
        end else if (bypass) begin
            dq_packet = id_packet;
        end

        // A bypassed packet is consumed by the RS directly, so it is not
        // written and does not count as a queue dequeue either.
        enq = id_valid && id_ready && !bypass;
        deq = !empty && rs_ready;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            // Anything enqueued or dequeued in the squash cycle is dropped.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; entries are only read when counted as valid.
    always_ff @(posedge clock) begin
        if (!reset && !squash && enq) begin
            mem_q[tail_q] <= id_packet;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(enq && full));
            assert (!(deq && empty));
            assert (count_q <= FULL_CNT);
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_dispatch_queue
//   Directed bench for dispatch_queue (DEPTH = 8). Inputs change 1 time unit
//   after the rising edge; outputs are sampled 1 unit later, clear of the edge.
// -----------------------------------------------------------------------------
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int CNT_W = $clog2(DQ_DEPTH + 1);

    logic                   clock = 1'b0;
    logic                   reset, squash, id_valid, rs_ready;
    logic [ID_RS_PKT_W-1:0] id_packet;
    logic                   id_ready, dq_valid, full, empty;
    logic [ID_RS_PKT_W-1:0] dq_packet;
    logic [CNT_W-1:0]       count;
    ID_RS_PACKET            head;

    int total = 0;
    int bad   = 0;

    dispatch_queue #(.DEPTH(DQ_DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .id_valid  (id_valid),
        .id_packet (id_packet),
        .id_ready  (id_ready),
        .rs_ready  (rs_ready),
        .dq_valid  (dq_valid),
        .dq_packet (dq_packet),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always #5 clock = ~clock;

    assign head = ID_RS_PACKET'(dq_packet);

    function automatic logic [ID_RS_PKT_W-1:0] mk(input logic [31:0] inst);
        ID_RS_PACKET p;
        p         = '0;
        p.inst    = inst;
        p.pc      = inst ^ 32'h0000_1000;
        p.fu_type = FU_ALU;
        p.valid   = 1'b1;
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; squash = 1'b0; id_valid = 1'b0; rs_ready = 1'b0; id_packet = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        // reset state
        chk("rst_count",    128'(count),     128'd0);
        chk("rst_empty",    128'(empty),     128'd1);
        chk("rst_full",     128'(full),      128'd0);
        chk("rst_dq_valid", 128'(dq_valid),  128'd0);
        chk("rst_dq_pkt",   128'(dq_packet), 128'd0);
        chk("rst_id_ready", 128'(id_ready),  128'd1);

        // three packets held by rs_ready=0, then drained in order
        id_valid = 1'b1; id_packet = mk(32'h0000_0013); tick();
        chk("lat1_inst", 128'(head.inst), 128'h13);
        id_packet = mk(32'h0000_2003); tick();
        id_packet = mk(32'h0000_2023); tick();
        id_valid = 1'b0; #1;
        chk("t1_count",    128'(count),     128'd3);
        chk("t1_head",     128'(head.inst), 128'h13);
        chk("t1_dq_valid", 128'(dq_valid),  128'd1);
        chk("t1_head_pkt", 128'(dq_packet), 128'(mk(32'h0000_0013)));
        rs_ready = 1'b1; #1;
        chk("t1_out0", 128'(head.inst), 128'h13);   tick();
        chk("t1_out1", 128'(head.inst), 128'h2003); tick();
        chk("t1_out2", 128'(head.inst), 128'h2023); tick();
        rs_ready = 1'b0; #1;
        chk("t1_empty",    128'(empty),    128'd1);
        chk("t1_dq_valid0",128'(dq_valid), 128'd0);
        chk("t1_count0",   128'(count),    128'd0);

        // fill to DEPTH, 9th packet refused, one pop reopens id_ready
        for (int i = 0; i < 8; i++) begin
            id_valid = 1'b1; id_packet = mk(32'h100 + 32'(i)); tick();
        end
        #1;
        chk("t2_full",     128'(full),     128'd1);
        chk("t2_id_ready", 128'(id_ready), 128'd0);
        chk("t2_count8",   128'(count),    128'd8);
        id_packet = mk(32'h999); tick();
        id_valid = 1'b0; #1;
        chk("t2_count_9th", 128'(count),     128'd8);
        chk("t2_head_9th",  128'(head.inst), 128'h100);
        rs_ready = 1'b1; tick();
        rs_ready = 1'b0; #1;
        chk("t2_count7",    128'(count),     128'd7);
        chk("t2_id_ready1", 128'(id_ready),  128'd1);
        chk("t2_full0",     128'(full),      128'd0);
        chk("t2_head1",     128'(head.inst), 128'h101);
        rs_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #1;
            chk("t2_drain", 128'(head.inst), 128'(32'h100 + 32'(i)));
            tick();
        end
        rs_ready = 1'b0; #1;
        chk("t2_no_9th", 128'(empty), 128'd1);

        // hold at 4 with simultaneous push/pop for 20 cycles; pointers wrap
        for (int i = 0; i < 4; i++) begin
            id_valid = 1'b1; id_packet = mk(32'h200 + 32'(i)); tick();
        end
        rs_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            id_packet = mk(32'h300 + 32'(k)); #1;
            chk("t3_count", 128'(count), 128'd4);
            chk("t3_order", 128'(head.inst),
                128'((k < 4) ? (32'h200 + 32'(k)) : (32'h300 + 32'(k - 4))));
            tick();
        end
        id_valid = 1'b0; rs_ready = 1'b0; #1;
        chk("t3_count_end", 128'(count),     128'd4);
        chk("t3_head_end",  128'(head.inst), 128'h310);

        // fill to 5, squash with a push in the same cycle
        id_valid = 1'b1; id_packet = mk(32'h314); tick();
        id_valid = 1'b0; #1;
        chk("t4_count5", 128'(count), 128'd5);
        squash = 1'b1; id_valid = 1'b1; rs_ready = 1'b1; id_packet = mk(32'h777); tick();
        squash = 1'b0; id_valid = 1'b0; rs_ready = 1'b0; #1;
        chk("t4_count0",    128'(count),    128'd0);
        chk("t4_empty",     128'(empty),    128'd1);
        chk("t4_dq_valid",  128'(dq_valid), 128'd0);
        id_valid = 1'b1; id_packet = mk(32'h888); tick();
        id_valid = 1'b0; #1;
        chk("t4_after_cnt", 128'(count),     128'd1);
        chk("t4_after_hd",  128'(head.inst), 128'h888);
        rs_ready = 1'b1; tick();
        rs_ready = 1'b0;

        // reset while holding 6 entries
        for (int i = 0; i < 6; i++) begin
            id_valid = 1'b1; id_packet = mk(32'h400 + 32'(i)); tick();
        end
        id_valid = 1'b0; #1;
        chk("t5_count6", 128'(count), 128'd6);
        reset = 1'b1; tick();
        reset = 1'b0; #1;
        chk("t5_count0",   128'(count),     128'd0);
        chk("t5_dq_pkt",   128'(dq_packet), 128'd0);
        chk("t5_id_ready", 128'(id_ready),  128'd1);
        chk("t5_empty",    128'(empty),     128'd1);

        // empty queue, packet with rs_ready high
        id_valid = 1'b1; rs_ready = 1'b1; id_packet = mk(32'h00B5_0533); #1;
`ifdef DQ_BYPASS_EN
        chk("t6_byp_valid", 128'(dq_valid),  128'd1);
        chk("t6_byp_inst",  128'(head.inst), 128'h00B5_0533);
        tick();
        id_valid = 1'b0; rs_ready = 1'b0; #1;
        chk("t6_byp_count", 128'(count), 128'd0);
        chk("t6_byp_empty", 128'(empty), 128'd1);
`else
        chk("t6_same_valid", 128'(dq_valid), 128'd0);
        tick();
        id_valid = 1'b0; rs_ready = 1'b0; #1;
        chk("t6_next_count", 128'(count),     128'd1);
        chk("t6_next_inst",  128'(head.inst), 128'h00B5_0533);
        chk("t6_next_valid", 128'(dq_valid),  128'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
